// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request after last_idx, modulo N_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_idx,
    output logic             any,
    output logic [IW-1:0]    idx
);

    always_comb begin
        logic [IW-1:0] j;
        any = 1'b0;
        idx = '0;
        j   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = IW'((int'(last_idx) + k) % N_REQ);
            if (!any && req[j]) begin
                any = 1'b1;
                idx = j;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among N_REQ
// burst requesters; a grant is held until last beat or MAX_BURST.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                clka,
    input  logic                resetb,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [N_REQ-1:0]    req_last,
    output logic [N_REQ-1:0]    req_ready,
    input  logic                fifo_full,
    output logic                fifo_wr,
    output logic [DW-1:0]       fifo_din,
    output logic [N_REQ-1:0]    grant_oh,
    output logic                busy
);

    localparam int IW = idx_w(N_REQ);
    localparam int CW = idx_w(MAX_BURST);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_REQ  = IW'(N_REQ - 1);

    arb_state_t    state, state_n;
    logic [IW-1:0] grant_idx, grant_n;
    logic [IW-1:0] last_idx, last_n;
    logic [CW-1:0] beat_cnt, cnt_n;
    logic          pick_any;
    logic [IW-1:0] pick_idx;
    logic [DW-1:0] data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DW +: DW];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req      (req_valid),
        .last_idx (last_idx),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    always_ff @(posedge clka) begin
        if (!resetb) begin
            state     <= IDLE;
            grant_idx <= '0;
            last_idx  <= LAST_REQ;
            beat_cnt  <= '0;
        end else begin
            state     <= state_n;
            grant_idx <= grant_n;
            last_idx  <= last_n;
            beat_cnt  <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant_idx;
        last_n  = last_idx;
        cnt_n   = beat_cnt;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_n = pick_idx;
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                // full or idle owner leaves state and count untouched
                if (fifo_wr) begin
                    if (req_last[grant_idx] ||
                        beat_cnt == LAST_BEAT) begin
                        state_n = IDLE;
                        last_n  = grant_idx;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        fifo_wr   = 1'b0;
        fifo_din  = '0;
        grant_oh  = '0;
        busy      = 1'b0;
        if (state == BUSY) begin
            busy                 = 1'b1;
            grant_oh[grant_idx]  = 1'b1;
            req_ready[grant_idx] = ~fifo_full;
            fifo_wr  = req_valid[grant_idx] & ~fifo_full;
            fifo_din = data_arr[grant_idx];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter.
// Per-requester beat queues plus a round-robin grant model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic            clka = 1'b0;
    logic            resetb = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_full = 1'b0;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_din;
    logic [N-1:0]    grant_oh;
    logic            busy;

    always #5 clka = ~clka;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DW        (DW),
        .MAX_BURST (MB)
    ) dut (
        .clka      (clka),
        .resetb    (resetb),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .grant_oh  (grant_oh),
        .busy      (busy)
    );

    // beat = {last, data}
    logic [DW:0] send_q [N][$];
    logic [DW:0] exp_q  [N][$];

    int n_chk = 0;
    int n_err = 0;
    int vprob = 100;
    int fprob = 0;
    bit refill = 1'b0;
    int full_run = 0;
    int drop_req = 0;
    int drop_cnt = 0;

    bit rst_edge = 1'b1;
    int m_owner = -1;
    int m_last = N - 1;
    int m_beats = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [N-1:0] v,
                              input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    always @(posedge clka) rst_edge <= !resetb;

    // monitor: compares DUT against the round-robin/burst model
    always @(negedge clka) begin
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         ew;
        logic [DW:0]  b;
        int           nxt;
        if (rst_edge) begin
            m_owner = -1;
            m_last  = N - 1;
            m_beats = 0;
        end
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("grant_oh", grant_oh, eg);
        chk("busy", busy, m_owner >= 0);
        nxt = m_owner;
        if (m_owner >= 0) begin
            er = fifo_full ? '0 : eg;
            ew = req_valid[m_owner] & ~fifo_full;
            chk("req_ready", req_ready, er);
            chk("fifo_wr", fifo_wr, ew);
            if (ew) begin
                if (exp_q[m_owner].size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_beat: req %0d none queued",
                             m_owner);
                end else begin
                    b = exp_q[m_owner].pop_front();
                    chk("fifo_din", fifo_din, b[DW-1:0]);
                    m_beats++;
                    if (b[DW] || m_beats == MB) begin
                        m_last = m_owner;
                        nxt = -1;
                    end
                end
            end
        end else begin
            chk("idle_ready", req_ready, 0);
            chk("idle_wr", fifo_wr, 0);
            chk("idle_din", fifo_din, 0);
            if (req_valid != '0) begin
                nxt = rr(req_valid, m_last);
                m_beats = 0;
            end
        end
        m_owner = nxt;
    end

    task automatic push_burst(input int i, input int len);
        logic [DW:0] x;
        for (int b = 0; b < len; b++) begin
            x = {b == len - 1, DW'($urandom)};
            send_q[i].push_back(x);
            exp_q[i].push_back(x);
        end
    endtask

    task automatic drive();
        logic [DW:0] x;
        for (int i = 0; i < N; i++) begin
            if (send_q[i].size() > 0) begin
                x = send_q[i][0];
                req_valid[i] = $urandom_range(0, 99) < vprob;
                if (drop_cnt > 0 && i == drop_req)
                    req_valid[i] = 1'b0;
                req_last[i] = x[DW];
                req_data[i*DW +: DW] = x[DW-1:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i] = 1'b0;
                req_data[i*DW +: DW] = '0;
            end
        end
        if (drop_cnt > 0) drop_cnt--;
        if (full_run > 0) begin
            fifo_full = 1'b1;
            full_run--;
        end else if ($urandom_range(0, 99) < fprob) begin
            fifo_full = 1'b1;
            full_run = $urandom_range(0, 4);
        end else begin
            fifo_full = 1'b0;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] acc;
        @(negedge clka);
        acc = req_valid & req_ready;
        @(posedge clka);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i] && send_q[i].size() > 0)
                void'(send_q[i].pop_front());
        if (refill)
            for (int i = 0; i < N; i++)
                if (send_q[i].size() == 0 &&
                    $urandom_range(0, 9) < 3)
                    push_burst(i, ($urandom_range(0, 9) < 2) ?
                               $urandom_range(17, 20) :
                               $urandom_range(1, 6));
        drive();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        req_valid = '0;
        @(negedge clka);
        @(posedge clka);
        #1;
        for (int i = 0; i < N; i++) begin
            send_q[i].delete();
            exp_q[i].delete();
        end
        resetb = 1'b1;
        drive();
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += exp_q[i].size();
        return s;
    endfunction

    initial begin
        @(posedge clka);
        #1;
        do_reset();
        run(2);
        push_burst(0, 3);
        drive();
        run(8);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_burst(i, 1);
        drive();
        run(20);
        push_burst(2, 20);
        push_burst(0, 2);
        push_burst(3, 2);
        drive();
        run(45);
        push_burst(1, 8);
        drive();
        run(3);
        full_run = 5;
        drive();
        run(20);
        push_burst(0, 6);
        push_burst(3, 2);
        drive();
        run(3);
        drop_req = 0;
        drop_cnt = 3;
        drive();
        run(20);
        push_burst(0, 6);
        drive();
        run(3);
        do_reset();
        for (int i = 0; i < N; i++) push_burst(i, 1);
        drive();
        run(15);
        refill = 1'b1;
        vprob = 75;
        fprob = 5;
        run(1500);
        do_reset();
        run(1500);
        refill = 1'b0;
        vprob = 100;
        fprob = 0;
        for (int c = 0; c < 3000 && pending() > 0; c++) cycle();
        chk("drain_left", pending(), 0);
        run(4);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single 8-bit write port of the team's FIFO among N_REQ requesters.
Each requester presents bursts using a valid/ready/last handshake. Once granted, a requester holds the port until it sends its last beat or reaches the burst limit.
The block sits directly in front of the FIFO write side: it drives wr/din and observes full, all in the clka domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 8, data width; matches FIFO din
MAX_BURST, 16, maximum beats per grant before forced release (>=1)

Ports:
clka  input  1  clock
resetb  input  1  reset, synchronous, active-low; clock clka
req_valid  input  N_REQ  per-requester beat valid
req_data  input  N_REQ*DW  packed data; requester i occupies bits [i*DW +: DW]
req_last  input  N_REQ  per-requester last-beat-of-burst flag
req_ready  output  N_REQ  per-requester beat accepted this cycle
fifo_full  input  1  FIFO full flag
fifo_wr  output  1  FIFO write strobe
fifo_din  output  DW  FIFO write data
grant_oh  output  N_REQ  one-hot current owner; 0 when idle
busy  output  1  high while state is BUSY

Behaviour:
- Reset values (next clka edge with resetb=0):
  - state=IDLE, grant_idx=0, last_idx=N_REQ-1 (so requester 0 has first priority), beat_cnt=0.
  - Combinational outputs then read: req_ready=0, fifo_wr=0, fifo_din=0, grant_oh=0, busy=0.
- FSM states: IDLE, BUSY.
- IDLE:
  - No transfers occur.
  - If any req_valid is set, select the first set index scanning last_idx+1, last_idx+2, ... modulo N_REQ.
  - Register the selection into grant_idx, clear beat_cnt, and go to BUSY.
  - Arbitration latency: 1 cycle from valid to grant; first transfer possible on the following cycle.
- BUSY:
  - Port-level signals:
    - req_ready[grant_idx] = ~fifo_full; all other ready bits = 0.
    - fifo_wr = req_valid[grant_idx] & ~fifo_full (zero-latency pass-through).
    - fifo_din = req_data of grant_idx.
  - A transfer happens when fifo_wr=1. On each transfer, beat_cnt increments.
  - If req_last[grant_idx]=1 or beat_cnt==MAX_BURST-1: go to IDLE, last_idx<=grant_idx, beat_cnt<=0.
- Grant lock:
  - If the owner deasserts valid mid-burst, the grant is held; there is no timeout.
  - Other requesters wait regardless of their valid state.
- Full backpressure: while fifo_full=1, fifo_wr=0 and req_ready=0; state and beat_cnt are unchanged.
- Back-to-back bursts: one IDLE bubble cycle is always inserted between grants.
  - A requester that is still valid after release loses priority to any other valid requester.
- Single requester: re-granted after the bubble; this is allowed.
- fifo_din in IDLE is 0. In BUSY without a transfer it is don't-care (the mux of grant_idx).
- Widths:
  - beat_cnt width = max(1, $clog2(MAX_BURST)).
  - grant_idx and last_idx width = max(1, $clog2(N_REQ)).
  - Index wrap is modulo N_REQ (not a power-of-two wrap).
- Reset mid-burst: the next edge returns the block to IDLE with reset values. The partial burst is abandoned and the requester must resend.
- req_ready has no combinational dependency on req_valid (only on state, grant_idx, fifo_full).

Decomposition:
- Package fifo_arb_pkg:
  - arb_state_t enum {IDLE, BUSY}.
  - Helper function idx_w(n) returning max(1, $clog2(n)).
- Sub-module rr_pick:
  - Combinational rotating priority encoder.
  - Inputs: req[N_REQ], last_idx. Outputs: any, idx.
  - Instantiated once in IDLE arbitration.

Test Plan:
1. Reset, then req_valid=4'b0001 with 3 beats A0,A1,A2 (last on A2), fifo_full=0.
   -> grant_oh=0001 one cycle after valid; fifo_wr high 3 consecutive cycles with din A0,A1,A2; IDLE after A2.
2. All four requesters valid, each sending 1-beat bursts, held continuously.
   -> grant order 0,1,2,3,0; one IDLE cycle between each grant; each burst is a single write.
3. Requester 2 sends a 20-beat burst with no last, MAX_BURST=16.
   -> release after 16 writes; other valid requesters granted next; requester 2 regains the port later and continues.
4. fifo_full=1 for 5 cycles mid-burst of requester 1.
   -> fifo_wr=0 and req_ready=0 for those cycles; beat order and count preserved; no beat lost or duplicated.
5. Owner drops valid for 3 cycles mid-burst while requester 3 is valid.
   -> grant stays with owner; requester 3 ready stays 0 until owner's last beat.
6. resetb=0 asserted during beat 2 of a burst.
   -> next edge: busy=0, grant_oh=0, fifo_wr=0; after release requester 0 has priority again.
